// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl: bridges a 32-bit CPU request bus to an external asynchronous
// 16-bit SRAM. Each word access becomes one or two halfword SRAM cycles:
// SETUP, STROBE (WAIT+1 cycles), RECOV, and a final one-cycle DONE/ready pulse.
// Every pad-facing output comes straight from a flop.
module ext_sram_ctrl #(
  parameter int ADDR_W = 18,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [ADDR_W:0]   addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] xa,
  output logic [15:0]       xdo,
  input  logic [15:0]       xdi,
  output logic              xdo_en,
  output logic              xcs_n,
  output logic              xoe_n,
  output logic              xwe_n,
  output logic              xble_n,
  output logic              xbhe_n
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_RECOV  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT);

  logic [2:0]        state_q, state_d;
  logic              h_q, h_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] xa_q, xa_d;
  logic [15:0]       xdo_q, xdo_d;
  logic              xdo_en_q, xdo_en_d;
  logic              xcs_n_q, xcs_n_d;
  logic              xoe_n_q, xoe_n_d;
  logic              xwe_n_q, xwe_n_d;
  logic              xble_n_q, xble_n_d;
  logic              xbhe_n_q, xbhe_n_d;

  logic              setup_go;
  logic              setup_h;
  logic              is_write;
  logic [ADDR_W-2:0] src_addr;
  logic [3:0]        src_we;
  logic [31:0]       src_wdata;

  // The byte offset bits of a word address carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Next-state and next-output logic; SETUP outputs are computed on entry so they appear registered in SETUP.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    xa_d      = xa_q;
    xdo_d     = xdo_q;
    xdo_en_d  = xdo_en_q;
    xcs_n_d   = xcs_n_q;
    xoe_n_d   = xoe_n_q;
    xwe_n_d   = xwe_n_q;
    xble_n_d  = xble_n_q;
    xbhe_n_d  = xbhe_n_q;
    setup_go  = 1'b0;
    setup_h   = 1'b0;
    is_write  = (we_q != 4'b0000);
    src_addr  = addr_q;
    src_we    = we_q;
    src_wdata = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          addr_d    = addr[ADDR_W:2];
          we_d      = we;
          wdata_d   = wdata;
          src_addr  = addr[ADDR_W:2];
          src_we    = we;
          src_wdata = wdata;
          setup_go  = 1'b1;
          setup_h   = (we != 4'b0000) && (we[1:0] == 2'b00);
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = 3'd0;
        if (is_write) begin
          xwe_n_d = 1'b0;
        end else begin
          xoe_n_d = 1'b0;
        end
      end
      S_STROBE: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RECOV;
          xoe_n_d = 1'b1;
          xwe_n_d = 1'b1;
          if (!is_write) begin
            if (h_q) begin
              rdata_d[31:16] = xdi;
            end else begin
              rdata_d[15:0] = xdi;
            end
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RECOV: begin
        if (!h_q && (!is_write || (we_q[3:2] != 2'b00))) begin
          setup_go = 1'b1;
          setup_h  = 1'b1;
        end else begin
          state_d  = S_DONE;
          ready_d  = 1'b1;
          xcs_n_d  = 1'b1;
          xdo_en_d = 1'b0;
          xble_n_d = 1'b1;
          xbhe_n_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (setup_go) begin
      state_d = S_SETUP;
      h_d     = setup_h;
      xa_d    = {src_addr, setup_h};
      xcs_n_d = 1'b0;
      xoe_n_d = 1'b1;
      xwe_n_d = 1'b1;
      if (src_we != 4'b0000) begin
        xble_n_d = ~(setup_h ? src_we[2] : src_we[0]);
        xbhe_n_d = ~(setup_h ? src_we[3] : src_we[1]);
        xdo_d    = setup_h ? src_wdata[31:16] : src_wdata[15:0];
        xdo_en_d = 1'b1;
      end else begin
        xble_n_d = 1'b0;
        xbhe_n_d = 1'b0;
        xdo_en_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset to an idle, deselected bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      h_q      <= 1'b0;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      we_q     <= 4'b0000;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      ready_q  <= 1'b0;
      xa_q     <= '0;
      xdo_q    <= 16'd0;
      xdo_en_q <= 1'b0;
      xcs_n_q  <= 1'b1;
      xoe_n_q  <= 1'b1;
      xwe_n_q  <= 1'b1;
      xble_n_q <= 1'b1;
      xbhe_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      xa_q     <= xa_d;
      xdo_q    <= xdo_d;
      xdo_en_q <= xdo_en_d;
      xcs_n_q  <= xcs_n_d;
      xoe_n_q  <= xoe_n_d;
      xwe_n_q  <= xwe_n_d;
      xble_n_q <= xble_n_d;
      xbhe_n_q <= xbhe_n_d;
    end
  end

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign xa     = xa_q;
  assign xdo    = xdo_q;
  assign xdo_en = xdo_en_q;
  assign xcs_n  = xcs_n_q;
  assign xoe_n  = xoe_n_q;
  assign xwe_n  = xwe_n_q;
  assign xble_n = xble_n_q;
  assign xbhe_n = xbhe_n_q;

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// tb_ext_sram_ctrl: scoreboard bench for ext_sram_ctrl. dut0 runs with WAIT=1,
// dut1 with WAIT=0 for back-to-back reads. A shared behavioural SRAM answers both.
module tb_ext_sram_ctrl;

  localparam int AW = 18;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          nh;
    int          strobes;
    bit          wr;
    logic [17:0] xa_a;
    logic [17:0] xa_b;
    logic [15:0] xdo_a;
    logic [15:0] xdo_b;
    logic [1:0]  ln_a;
    logic [1:0]  ln_b;
    int          gap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, valid0, ready0, xdo_en0, xcs_n0, xoe_n0, xwe_n0, xble_n0, xbhe_n0;
  logic [AW:0] addr0;
  logic [3:0]  we0;
  logic [31:0] wdata0, rdata0;
  logic [AW-1:0] xa0;
  logic [15:0] xdo0, xdi0;

  logic        reset1, valid1, ready1, xdo_en1, xcs_n1, xoe_n1, xwe_n1, xble_n1, xbhe_n1;
  logic [AW:0] addr1;
  logic [3:0]  we1;
  logic [31:0] wdata1, rdata1;
  logic [AW-1:0] xa1;
  logic [15:0] xdo1, xdi1;

  ext_sram_ctrl #(.ADDR_W(AW), .WAIT(1)) dut0 (
    .clk(clk), .reset(reset0), .valid(valid0), .addr(addr0), .we(we0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .xa(xa0), .xdo(xdo0), .xdi(xdi0), .xdo_en(xdo_en0),
    .xcs_n(xcs_n0), .xoe_n(xoe_n0), .xwe_n(xwe_n0), .xble_n(xble_n0), .xbhe_n(xbhe_n0)
  );

  ext_sram_ctrl #(.ADDR_W(AW), .WAIT(0)) dut1 (
    .clk(clk), .reset(reset1), .valid(valid1), .addr(addr1), .we(we1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .xa(xa1), .xdo(xdo1), .xdi(xdi1), .xdo_en(xdo_en1),
    .xcs_n(xcs_n1), .xoe_n(xoe_n1), .xwe_n(xwe_n1), .xble_n(xble_n1), .xbhe_n(xbhe_n1)
  );

  // Behavioural SRAM: asynchronous read while selected and output-enabled.
  logic [15:0] mem [0:1023];

  always_comb begin
    xdi0 = (!xcs_n0 && !xoe_n0) ? mem[xa0[9:0]] : 16'hF00F;
    xdi1 = (!xcs_n1 && !xoe_n1) ? mem[xa1[9:0]] : 16'hF00F;
  end

  // Write lanes of dut0 into the SRAM while its write strobe is low.
  always @(posedge clk) begin
    if (!xcs_n0 && !xwe_n0) begin
      if (!xble_n0) mem[xa0[9:0]][7:0] <= xdo0[7:0];
      if (!xbhe_n0) mem[xa0[9:0]][15:8] <= xdo0[15:8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input int lat, input int nh, input int st,
                              input bit wr, input logic [17:0] xaa, input logic [17:0] xab,
                              input logic [15:0] xda, input logic [15:0] xdb,
                              input logic [1:0] lna, input logic [1:0] lnb, input int gap);
    exp_t e;
    e.rdata = rd; e.lat = lat; e.nh = nh; e.strobes = st; e.wr = wr;
    e.xa_a = xaa; e.xa_b = xab; e.xdo_a = xda; e.xdo_b = xdb;
    e.ln_a = lna; e.ln_b = lnb; e.gap = gap;
    return e;
  endfunction

  // Issue one dut0 transaction, holding valid until ready or the cycle budget runs out.
  task automatic applyStimulus(input logic [AW:0] a, input logic [3:0] w, input logic [31:0] d,
                               input exp_t e);
    bit got;
    got = 1'b0;
    q0.push_back(e);
    @(posedge clk); #2;
    valid0 = 1'b1; addr0 = a; we0 = w; wdata0 = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (ready0) begin
        got = 1'b1;
        break;
      end
    end
    valid0 = 1'b0;
    checkOutput("ready0_seen", {31'b0, got}, 32'd1);
  endtask

  // Monitor for dut0: bus invariants every cycle, per-transaction capture, scoreboard compare on ready.
  int          cyc0 = 0, start0 = 0, nh0 = 0, st0 = 0;
  logic        p_cs0 = 1'b1, p_oe0 = 1'b1, p_we0 = 1'b1;
  logic [17:0] p_xa0 = '0, c_xa_a = '0, c_xa_b = '0;
  logic [15:0] p_xdo0 = '0, c_xdo_a = '0, c_xdo_b = '0;
  logic [1:0]  c_ln_a = '0, c_ln_b = '0;
  logic        c_en_a = 1'b0, c_en_b = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc0++;
    checkOutput("oe_we_exclusive0", {31'b0, xoe_n0 | xwe_n0}, 32'd1);
    checkOutput("xdo_en_in_read0", {31'b0, !xoe_n0 && xdo_en0}, 32'd0);
    if (!xwe_n0 && !p_we0) begin
      checkOutput("xa_stable_we0", 32'(xa0), 32'(p_xa0));
      checkOutput("xdo_stable_we0", 32'(xdo0), 32'(p_xdo0));
    end
    if (!xcs_n0 && p_cs0) begin
      start0 = cyc0; nh0 = 0; st0 = 0;
    end
    if (!xoe_n0 || !xwe_n0) begin
      st0++;
      if (p_oe0 && p_we0) begin
        if (nh0 == 0) begin
          c_xa_a = xa0; c_xdo_a = xdo0; c_ln_a = {xbhe_n0, xble_n0}; c_en_a = xdo_en0;
        end else begin
          c_xa_b = xa0; c_xdo_b = xdo0; c_ln_b = {xbhe_n0, xble_n0}; c_en_b = xdo_en0;
        end
        nh0++;
      end
    end
    if (ready0) begin
      if (q0.size() == 0) begin
        checkOutput("unexpected_ready0", {31'b0, ready0}, 32'd0);
      end else begin
        e = q0.pop_front();
        checkOutput("latency0", cyc0 - start0 + 1, e.lat);
        checkOutput("halves0", nh0, e.nh);
        checkOutput("strobe_cycles0", st0, e.strobes);
        checkOutput("rdata0", rdata0, e.rdata);
        checkOutput("xa_half_a", 32'(c_xa_a), 32'(e.xa_a));
        checkOutput("lanes_half_a", 32'(c_ln_a), 32'(e.ln_a));
        checkOutput("xdo_en_half_a", {31'b0, c_en_a}, {31'b0, e.wr});
        if (e.wr) checkOutput("xdo_half_a", 32'(c_xdo_a), 32'(e.xdo_a));
        if (e.nh > 1) begin
          checkOutput("xa_half_b", 32'(c_xa_b), 32'(e.xa_b));
          checkOutput("lanes_half_b", 32'(c_ln_b), 32'(e.ln_b));
          checkOutput("xdo_en_half_b", {31'b0, c_en_b}, {31'b0, e.wr});
          if (e.wr) checkOutput("xdo_half_b", 32'(c_xdo_b), 32'(e.xdo_b));
        end
      end
    end
    p_cs0 = xcs_n0; p_oe0 = xoe_n0; p_we0 = xwe_n0; p_xa0 = xa0; p_xdo0 = xdo0;
  end

  // Monitor for dut1: latency, strobe width, read data and spacing between ready pulses.
  int   cyc1 = 0, start1 = 0, st1 = 0, last_rdy1 = 0;
  logic p_cs1 = 1'b1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc1++;
    checkOutput("oe_we_exclusive1", {31'b0, xoe_n1 | xwe_n1}, 32'd1);
    if (!xcs_n1 && p_cs1) begin
      start1 = cyc1; st1 = 0;
    end
    if (!xoe_n1 || !xwe_n1) st1++;
    if (ready1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected_ready1", {31'b0, ready1}, 32'd0);
      end else begin
        e = q1.pop_front();
        checkOutput("latency1", cyc1 - start1 + 1, e.lat);
        checkOutput("strobe_cycles1", st1, e.strobes);
        checkOutput("rdata1", rdata1, e.rdata);
        checkOutput("xdo_en1", {31'b0, xdo_en1}, 32'd0);
        if (e.gap > 0) checkOutput("ready_period1", cyc1 - last_rdy1, e.gap);
      end
      last_rdy1 = cyc1;
    end
    p_cs1 = xcs_n1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    reset0 = 1'b1; valid0 = 1'b0; addr0 = '0; we0 = 4'h0; wdata0 = 32'd0;
    reset1 = 1'b1; valid1 = 1'b0; addr1 = '0; we1 = 4'h0; wdata1 = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    #1;
    mem[16] <= 16'h1234;  mem[17] <= 16'hABCD;
    mem[3]  <= 16'h1177;  mem[4]  <= 16'h9999;  mem[5] <= 16'h7777;
    mem[256] <= 16'h3333; mem[257] <= 16'h4444;
    mem[260] <= 16'h5555; mem[261] <= 16'h6666;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_ready", {31'b0, ready0}, 32'd0);
    checkOutput("rst_rdata", rdata0, 32'd0);
    checkOutput("rst_xa", 32'(xa0), 32'd0);
    checkOutput("rst_xdo", 32'(xdo0), 32'd0);
    checkOutput("rst_xdo_en", {31'b0, xdo_en0}, 32'd0);
    checkOutput("rst_strobes_n", {27'b0, xcs_n0, xoe_n0, xwe_n0, xble_n0, xbhe_n0}, 32'h1F);
    checkOutput("rst_xcs_n1", {31'b0, xcs_n1}, 32'd1);
    reset0 = 1'b0; reset1 = 1'b0;

    // Full read: halves at xa 0x10 and 0x11.
    applyStimulus(19'h00020, 4'h0, 32'd0,
      mk(32'hABCD1234, 9, 2, 4, 1'b0, 18'h10, 18'h11, 16'h0, 16'h0, 2'b00, 2'b00, -1));

    // Word write; rdata keeps the previous read value.
    applyStimulus(19'h00040, 4'hF, 32'hDEADBEEF,
      mk(32'hABCD1234, 9, 2, 4, 1'b1, 18'h20, 18'h21, 16'hBEEF, 16'hDEAD, 2'b00, 2'b00, -1));
    checkOutput("mem_0x20", 32'(mem[32]), 32'h0000BEEF);
    checkOutput("mem_0x21", 32'(mem[33]), 32'h0000DEAD);

    // Upper byte write: only the high half, high lane.
    applyStimulus(19'h00004, 4'b1000, 32'h5A000000,
      mk(32'hABCD1234, 5, 1, 2, 1'b1, 18'h3, 18'h0, 16'h5A00, 16'h0, 2'b01, 2'b00, -1));
    checkOutput("mem_0x3_upper_only", 32'(mem[3]), 32'h00005A77);

    // Low halfword write: only the low half is touched.
    applyStimulus(19'h00008, 4'b0011, 32'h0000CAFE,
      mk(32'hABCD1234, 5, 1, 2, 1'b1, 18'h4, 18'h0, 16'hCAFE, 16'h0, 2'b00, 2'b00, -1));
    checkOutput("mem_0x4", 32'(mem[4]), 32'h0000CAFE);
    checkOutput("mem_0x5_untouched", 32'(mem[5]), 32'h00007777);

    // Reset during the first write strobe cycle.
    @(posedge clk); #2;
    valid0 = 1'b1; addr0 = 19'h00080; we0 = 4'hF; wdata0 = 32'h11112222;
    @(posedge clk); #2;
    valid0 = 1'b0;
    checkOutput("midrst_setup_xcs_n", {31'b0, xcs_n0}, 32'd0);
    @(posedge clk); #2;
    checkOutput("midrst_strobe_xwe_n", {31'b0, xwe_n0}, 32'd0);
    reset0 = 1'b1;
    @(posedge clk); #2;
    checkOutput("midrst_xwe_n", {31'b0, xwe_n0}, 32'd1);
    checkOutput("midrst_xcs_n", {31'b0, xcs_n0}, 32'd1);
    checkOutput("midrst_xdo_en", {31'b0, xdo_en0}, 32'd0);
    checkOutput("midrst_ready", {31'b0, ready0}, 32'd0);
    checkOutput("midrst_rdata", rdata0, 32'd0);
    checkOutput("midrst_xa", 32'(xa0), 32'd0);
    reset0 = 1'b0;
    repeat (4) @(posedge clk);

    // Read after reset returns the earlier word write.
    applyStimulus(19'h00040, 4'h0, 32'd0,
      mk(32'hDEADBEEF, 9, 2, 4, 1'b0, 18'h20, 18'h21, 16'h0, 16'h0, 2'b00, 2'b00, -1));

    // Back-to-back reads on the WAIT=0 instance with valid held high.
    q1.push_back(mk(32'h44443333, 7, 2, 2, 1'b0, 18'h100, 18'h101, 16'h0, 16'h0, 2'b00, 2'b00, -1));
    q1.push_back(mk(32'h66665555, 7, 2, 2, 1'b0, 18'h104, 18'h105, 16'h0, 16'h0, 2'b00, 2'b00, 8));
    @(posedge clk); #2;
    valid1 = 1'b1; addr1 = 19'h00200; we1 = 4'h0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (ready1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("ready1_first_seen", {31'b0, got}, 32'd1);
    addr1 = 19'h00208;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (ready1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("ready1_second_seen", {31'b0, got}, 32'd1);
    valid1 = 1'b0;

    repeat (4) @(posedge clk);
    #2;
    checkOutput("scoreboard0_drained", q0.size(), 32'd0);
    checkOutput("scoreboard1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
